// File: rtl/mem_pkg.sv
// Shared types for the data memory responder: access kinds, FSM states and
// the wait-state counter width.
package mem_pkg;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_SB   = 2'd1,
        WR_SH   = 2'd2,
        WR_SW   = 2'd3
    } write_ctrl_e;

    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_LB   = 3'd1,
        RD_LH   = 3'd2,
        RD_LW   = 3'd3,
        RD_LBU  = 3'd4,
        RD_LHU  = 3'd5,
        RD_RSV6 = 3'd6,
        RD_RSV7 = 3'd7
    } read_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Wide enough for WAIT_STATES up to 15.
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: store merge into the addressed word, load
// extract/extend, and access legality (alignment and control combinations).
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  write_ctrl_e write_ctrl,
    input  read_ctrl_e  read_ctrl,
    input  logic [31:0] mem_word,
    output logic        store_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        err
);

    logic        misalign;
    logic        illegal;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        misalign = 1'b0;
        if ((write_ctrl == WR_SH || read_ctrl == RD_LH || read_ctrl == RD_LHU) && addr_lo[0])
            misalign = 1'b1;
        if ((write_ctrl == WR_SW || read_ctrl == RD_LW) && (addr_lo != 2'b00))
            misalign = 1'b1;

        illegal = ((write_ctrl != WR_NONE) && (read_ctrl != RD_NONE)) ||
                  (read_ctrl == RD_RSV6) || (read_ctrl == RD_RSV7);

        err      = misalign | illegal;
        store_en = (write_ctrl != WR_NONE) && !err;
    end

    always_comb begin
        store_word = mem_word;
        case (write_ctrl)
            WR_SB:   store_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            WR_SH:   store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            WR_SW:   store_word = wdata;
            default: store_word = mem_word;
        endcase
    end

    always_comb begin
        sel_byte  = mem_word[{addr_lo, 3'b000} +: 8];
        sel_half  = mem_word[{addr_lo[1], 4'b0000} +: 16];
        load_data = 32'd0;
        if (!err) begin
            case (read_ctrl)
                RD_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
                RD_LH:   load_data = {{16{sel_half[15]}}, sel_half};
                RD_LW:   load_data = mem_word;
                RD_LBU:  load_data = {24'd0, sel_byte};
                RD_LHU:  load_data = {16'd0, sel_half};
                default: load_data = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed-latency request/response handshake:
// one outstanding access, response strobe WAIT_STATES+1 cycles after accept.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  write_ctrl,
    input  logic [2:0]  read_ctrl,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    mem_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W+1:0]        addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    write_ctrl_e             wr_q, wr_d;
    read_ctrl_e              rd_q, rd_d;

    logic [31:0]             mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]        idx;
    logic [31:0]             mem_word;
    logic                    store_en;
    logic [31:0]             store_word;
    logic [31:0]             load_data;
    logic                    lane_err;
    logic                    unused_addr_hi;

    // Address bits above the storage index are deliberately discarded (wrap).
    assign unused_addr_hi = ^addr[31:IDX_W+2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= WR_NONE;
            rd_q    <= RD_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = addr[IDX_W+1:0];
                    wdata_d = wdata;
                    wr_d    = write_ctrl_e'(write_ctrl);
                    rd_d    = read_ctrl_e'(read_ctrl);
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign idx      = addr_q[IDX_W+1:2];
    assign mem_word = mem_q[idx];

    byte_lane_unit u_lanes (
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .write_ctrl (wr_q),
        .read_ctrl  (rd_q),
        .mem_word   (mem_word),
        .store_en   (store_en),
        .store_word (store_word),
        .load_data  (load_data),
        .err        (lane_err)
    );

    // Storage survives reset; a store only lands on the RESP edge.
    always_ff @(posedge clk) begin
        if (state_q == ST_RESP && store_en)
            mem_q[idx] <= store_word;
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rdata     = rsp_valid ? load_data : 32'd0;
    assign err       = rsp_valid & lane_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency, lane merge/extend, errors,
// address wrap, reset mid-transaction and zero-wait back-to-back throughput.
module tb_data_mem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  write_ctrl = '0;
    logic [2:0]  read_ctrl = '0;
    logic        req_ready, rsp_valid, err, busy;
    logic [31:0] rdata;

    logic        req_valid_0 = 1'b0;
    logic        req_ready_0, rsp_valid_0, err_0, busy_0;
    logic [31:0] rdata_0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .wdata(wdata), .write_ctrl(write_ctrl), .read_ctrl(read_ctrl),
        .rsp_valid(rsp_valid), .rdata(rdata), .err(err), .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_0), .req_ready(req_ready_0),
        .addr(32'd0), .wdata(32'd0), .write_ctrl(2'd0), .read_ctrl(3'd0),
        .rsp_valid(rsp_valid_0), .rdata(rdata_0), .err(err_0), .busy(busy_0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, and check the response.
    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] wc, input logic [2:0] rc,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        bit got;
        @(negedge clk);
        req_valid = 1'b1; addr = a; wdata = wd; write_ctrl = wc; read_ctrl = rc;
        @(posedge clk);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1'b1;
            if (n == 1) begin
                req_valid = 1'b0; addr = 32'hFFFF_FFFC; wdata = ~wd;
                write_ctrl = 2'd3; read_ctrl = 3'd3;
            end
        end
        chk({tag, ".lat"}, 32'(n), 32'(WS + 1));
        chk({tag, ".rdata"}, rdata, exp_rdata);
        chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk({tag, ".after"}, {28'd0, rsp_valid, err, req_ready, |rdata}, 32'h2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int rsp_seen;
        #2;
        chk("reset.ctl", {28'd0, req_ready, busy, rsp_valid, err}, 32'h8);
        chk("reset.rdata", rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        txn("sw10",  32'h10, 32'hDEADBEEF, 2'd3, 3'd0, 32'h0, 1'b0);
        txn("lw10a", 32'h10, 32'h0,        2'd0, 3'd3, 32'hDEADBEEF, 1'b0);
        txn("sb13",  32'h13, 32'h80,       2'd1, 3'd0, 32'h0, 1'b0);
        txn("lb13",  32'h13, 32'h0,        2'd0, 3'd1, 32'hFFFFFF80, 1'b0);
        txn("lbu13", 32'h13, 32'h0,        2'd0, 3'd4, 32'h00000080, 1'b0);
        txn("lw10b", 32'h10, 32'h0,        2'd0, 3'd3, 32'h80ADBEEF, 1'b0);
        txn("lh11",  32'h11, 32'h0,        2'd0, 3'd2, 32'h0, 1'b1);
        txn("sw12",  32'h12, 32'h12345678, 2'd3, 3'd0, 32'h0, 1'b1);
        txn("lw10c", 32'h10, 32'h0,        2'd0, 3'd3, 32'h80ADBEEF, 1'b0);
        txn("lh12",  32'h12, 32'h0,        2'd0, 3'd2, 32'hFFFF80AD, 1'b0);
        txn("lhu12", 32'h12, 32'h0,        2'd0, 3'd5, 32'h000080AD, 1'b0);
        txn("sh10",  32'h10, 32'hFFFF1234, 2'd2, 3'd0, 32'h0, 1'b0);
        txn("lw10d", 32'h10, 32'h0,        2'd0, 3'd3, 32'h80AD1234, 1'b0);
        txn("wr_rd", 32'h10, 32'h0BADF00D, 2'd3, 3'd3, 32'h0, 1'b1);
        txn("rsv6",  32'h10, 32'h0,        2'd0, 3'd6, 32'h0, 1'b1);
        txn("lw10e", 32'h10, 32'h0,        2'd0, 3'd3, 32'h80AD1234, 1'b0);
        txn("noop",  32'h10, 32'h0,        2'd0, 3'd0, 32'h0, 1'b0);
        txn("sw1000", 32'h1000, 32'hCAFEF00D, 2'd3, 3'd0, 32'h0, 1'b0);
        txn("lw0",   32'h0,  32'h0,        2'd0, 3'd3, 32'hCAFEF00D, 1'b0);
        txn("sw20a", 32'h20, 32'hA5A5A5A5, 2'd3, 3'd0, 32'h0, 1'b0);

        // Reset while a store is waiting: it must vanish without a trace.
        @(negedge clk);
        req_valid = 1'b1; addr = 32'h20; wdata = 32'h11111111;
        write_ctrl = 2'd3; read_ctrl = 3'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid.busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid.ctl", {28'd0, req_ready, busy, rsp_valid, err}, 32'h8);
        chk("rst_mid.rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        chk("rst_mid.norsp", 32'(rsp_seen), 32'd0);
        txn("lw20", 32'h20, 32'h0, 2'd0, 3'd3, 32'hA5A5A5A5, 1'b0);

        // Zero wait states with req_valid held: accept/response alternate.
        @(negedge clk);
        req_valid_0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b.%0d", i), {30'd0, req_ready_0, rsp_valid_0},
                (i % 2 == 0) ? 32'h2 : 32'h1);
            @(negedge clk);
        end
        req_valid_0 = 1'b0;
        chk("b2b.rdata", rdata_0 | {31'd0, err_0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
